// File: rtl/rf_tree_walker.sv
// Decision-tree traversal engine: walks internal nodes through an external
// signed comparator and returns the reached leaf class over valid/ready.
module rf_tree_walker #(
    parameter  int NODE_AW   = 10,
    parameter  int FEAT_AW   = 6,
    parameter  int CLASS_W   = 8,
    parameter  int COMP_LAT  = 2,
    parameter  int MAX_DEPTH = 31,
    localparam int NODE_W    = 1 + FEAT_AW + 24 + 2 * NODE_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [NODE_AW-1:0] root_addr,
    output logic [NODE_AW-1:0] node_addr,
    input  logic [NODE_W-1:0]  node_rdata,
    output logic [FEAT_AW-1:0] feat_addr,
    input  logic [23:0]        feat_rdata,
    output logic [23:0]        cmp_din1,
    output logic [23:0]        cmp_din2,
    input  logic               cmp_le,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLASS_W-1:0] res_class,
    output logic [5:0]         res_depth,
    output logic               res_err,
    output logic [2:0]         dbg_state_o
);

    localparam int RIGHT_LSB = 0;
    localparam int LEFT_LSB  = NODE_AW;
    localparam int THR_LSB   = 2 * NODE_AW;
    localparam int FIDX_LSB  = 2 * NODE_AW + 24;
    localparam int LEAF_BIT  = NODE_W - 1;
    localparam int CNT_W     = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NADDR = 3'd1,
        S_NDATA = 3'd2,
        S_FDATA = 3'd3,
        S_CMP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [NODE_AW-1:0] cur_addr_q, cur_addr_d;
    logic [5:0]         depth_q, depth_d;
    logic [23:0]        thr_q, thr_d;
    logic [NODE_AW-1:0] left_q, left_d;
    logic [NODE_AW-1:0] right_q, right_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CLASS_W-1:0] res_class_q, res_class_d;
    logic               res_err_q, res_err_d;

    logic               node_is_leaf;
    assign node_is_leaf = node_rdata[LEAF_BIT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            depth_q     <= '0;
            thr_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            cnt_q       <= '0;
            res_class_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            depth_q     <= depth_d;
            thr_q       <= thr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            cnt_q       <= cnt_d;
            res_class_q <= res_class_d;
            res_err_q   <= res_err_d;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the result fields stay frozen while res_valid is high and res_ready low.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        depth_d     = depth_q;
        thr_d       = thr_q;
        left_d      = left_q;
        right_d     = right_q;
        cnt_d       = cnt_q;
        res_class_d = res_class_q;
        res_err_d   = res_err_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    cur_addr_d = root_addr;
                    depth_d    = '0;
                    state_d    = S_NADDR;
                end
            end
            S_NADDR: begin
                state_d = S_NDATA;
            end
            S_NDATA: begin
                thr_d   = node_rdata[THR_LSB +: 24];
                left_d  = node_rdata[LEFT_LSB +: NODE_AW];
                right_d = node_rdata[RIGHT_LSB +: NODE_AW];
                if (node_is_leaf) begin
                    res_class_d = node_rdata[THR_LSB +: CLASS_W];
                    res_err_d   = 1'b0;
                    state_d     = S_DONE;
                end else if (depth_q == 6'(MAX_DEPTH)) begin
                    res_class_d = '0;
                    res_err_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_FDATA;
                end
            end
            S_FDATA: begin
                cnt_d   = CNT_W'(COMP_LAT - 1);
                state_d = S_CMP;
            end
            S_CMP: begin
                // cmp_le is only trusted on the cycle the countdown expires.
                if (cnt_q == '0) begin
                    cur_addr_d = cmp_le ? left_q : right_q;
                    depth_d    = depth_q + 6'd1;
                    state_d    = S_NADDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start_ready = rst_n && (state_q == S_IDLE);
    assign node_addr   = cur_addr_q;
    assign feat_addr   = (state_q == S_NDATA) ? node_rdata[FIDX_LSB +: FEAT_AW] : '0;
    assign cmp_din1    = (state_q == S_FDATA) ? feat_rdata : '0;
    assign cmp_din2    = (state_q == S_FDATA) ? thr_q : '0;
    assign res_valid   = (state_q == S_DONE);
    assign res_class   = res_class_q;
    assign res_depth   = depth_q;
    assign res_err     = res_err_q;
    assign dbg_state_o = state_q;

endmodule
